isqrt_pipelined: RTL and testbench
==================================

// Module: isqrt_pipelined
//
// PURPOSE
// Integer square root engine feeding the formula FSMs' isqrt_N_x / isqrt_N_y ports.
// Computes y = floor(sqrt(x)) for a 32-bit unsigned x, using the digit-by-digit (bit-pair) method.
// Fully pipelined: accepts a new argument every cycle, fixed latency, no backpressure.
// The caller pulses x_vld for one cycle only; in-order, no-stall results.
//
// PARAMETERS
// ITER_PER_STAGE  1   root bits resolved per pipeline stage; legal values 1,2,4,8,16
// LATENCY         16/ITER_PER_STAGE (derived localparam, not overridable)  cycles from x_vld to y_vld
//
// PORTS
// clk    input   1   clock; all logic on posedge
// rst    input   1   synchronous active-high reset
// x_vld  input   1   argument valid; one-cycle pulse per request, may be high every cycle
// x      input   32  unsigned argument, sampled when x_vld=1
// y_vld  output  1   result valid; exactly one pulse per accepted x_vld
// y      output  16  floor(sqrt(x)); don't-care ('x allowed) when y_vld=0
//
// BEHAVIOUR
// - Reset: on a clk edge with rst=1, every valid bit in the pipeline clears.
//   y_vld=0 from the next cycle on. Data registers are not reset.
// - Latency: x_vld=1 with x sampled at edge k -> y_vld=1 with matching y in the cycle after edge k+LATENCY-1.
//   LATENCY=16 at ITER_PER_STAGE=1.
// - Throughput: 1 result/cycle. Gaps in x_vld reproduce as identical gaps in y_vld. Order is preserved.
// - Stage state: remainder (18b signed/ext), partial root (16b), remaining radicand bits (32b), valid (1b).
// - Per iteration i (i = 15 down to 0):
//   - rem' = (rem<<2) | next two radicand MSBs
//   - trial = (root<<2) | 1
//   - if rem' >= trial: rem = rem' - trial; root = (root<<1) | 1
//   - else: rem = rem'; root = root<<1
//   - Widths must not truncate: rem needs 18 bits, root 16 bits.
// - Stage s performs iterations s*ITER_PER_STAGE .. (s+1)*ITER_PER_STAGE-1 combinationally, then registers.
// - Data-path registers load only when the incoming valid is 1 (saves toggling). Valid registers load every cycle.
// - Result must be exact for all 2^32 inputs: y*y <= x < (y+1)*(y+1), computed in 33-bit arithmetic.
// - Boundaries:
//   - x=0 -> 0
//   - x=0xFFFFFFFF -> 0xFFFF (no overflow of rem/root)
//   - perfect squares exact
//   - (y+1)^2-1 rounds down
// - Reset mid-operation: all in-flight requests are dropped, with no y_vld for them.
//   An x_vld coincident with rst=1 is ignored. The first x_vld after rst deasserts obeys normal latency.
// - No internal state persists between requests except pipeline contents. The block has no busy/ready concept.
//
// TESTING
// - Reset, then x=0 pulse at edge 0 -> y_vld high exactly LATENCY cycles later, y=0. No other y_vld pulses.
// - x=16, then x=17, then x=24, back-to-back on edges 0,1,2 -> y=4,4,4 on 3 consecutive cycles.
//   Then x=25 -> 5.
// - x=0xFFFFFFFF -> 0xFFFF; x=0xFFFE0001 -> 0xFFFF; x=0xFFFE0000 -> 0xFFFE.
// - Pattern x_vld=1,0,1,1,0 with x=1,-,2,3,- -> y_vld pattern 1,0,1,1,0 with y=1,-,1,1,- after LATENCY.
// - Inject 5 requests, assert rst for 1 cycle while 3 are in flight -> those 3 never appear.
//   A request issued the cycle after reset returns correctly.
// - 10^5 random x (incl. squares +/-1) with random x_vld, for ITER_PER_STAGE=1,4,16.
//   Scoreboard vs $floor($sqrt) model; check latency and count.

Source files
------------

// File: rtl/isqrt_pipelined_if.sv
// Bus between a formula FSM and the integer square root engine.
//
// Handshake: valid-only, no ready. The master pulses x_vld for one cycle with x
// stable on that edge. The slave answers with a one-cycle y_vld pulse for every
// accepted x_vld, in order, after a fixed latency. It cannot stall, so there is
// no backpressure. y is only meaningful while y_vld=1.
//
// Signals:
//   x_vld  master->slave  argument valid pulse
//   x      master->slave  32-bit unsigned argument
//   y_vld  slave->master  result valid pulse
//   y      slave->master  16-bit floor(sqrt(x))
interface isqrt_pipelined_if;
  logic        x_vld;
  logic [31:0] x;
  logic        y_vld;
  logic [15:0] y;

  modport master (output x_vld, output x, input y_vld, input y);
  modport slave  (input x_vld, input x, output y_vld, output y);
endinterface

// File: rtl/isqrt_pipelined.sv
// Fully pipelined 32-bit integer square root, y = floor(sqrt(x)).
// Uses the digit-by-digit (bit-pair) method. Each pipeline stage resolves
// ITER_PER_STAGE root bits combinationally and then registers the result.
// The block accepts one argument per cycle and has a fixed latency of
// 16/ITER_PER_STAGE cycles.
//
// Parameters:
//   ITER_PER_STAGE  root bits per stage; must be 1, 2, 4, 8 or 16
//
// Ports:
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset; clears only the valid bits
//   bus   isqrt_pipelined_if slave: x_vld/x in, y_vld/y out
module isqrt_pipelined #(
  parameter int ITER_PER_STAGE = 1
) (
  input  logic              clk,
  input  logic              rst,
  isqrt_pipelined_if.slave  bus
);

  localparam int LATENCY = 16 / ITER_PER_STAGE;

  // Per-stage state: remainder, partial root, and the radicand bits not yet
  // consumed. The next bit pair always sits in rad[31:30].
  typedef struct packed {
    logic [17:0] rem;
    logic [15:0] root;
    logic [31:0] rad;
  } stage_t;

  // One bit-pair iteration.
  // Before any shift the remainder is at most 2*root, with root no wider than
  // 15 bits, so it fits in 16 bits. That is why only rem[15:0] enters the
  // shifted value and the 18-bit result cannot overflow. The remainder
  // produced by the final iteration may need 17 bits, but it is never
  // shifted again.
  function automatic stage_t iterate(input stage_t s);
    stage_t      o;
    logic [17:0] rem_sh;
    logic [17:0] trial;
    rem_sh = {s.rem[15:0], s.rad[31:30]};
    trial  = {s.root, 2'b01};
    o.rad  = {s.rad[29:0], 2'b00};
    if (rem_sh >= trial) begin
      o.rem  = rem_sh - trial;
      o.root = {s.root[14:0], 1'b1};
    end else begin
      o.rem  = rem_sh;
      o.root = {s.root[14:0], 1'b0};
    end
    return o;
  endfunction

  function automatic stage_t run_stage(input stage_t s);
    stage_t t;
    t = s;
    for (int i = 0; i < ITER_PER_STAGE; i++) begin
      t = iterate(t);
    end
    return t;
  endfunction

  // Stage s reads in_d[s] and writes data_q[s+1].
  // Stage 0 reads the bus directly.
  stage_t in_d   [0:LATENCY-1];
  logic   vld_in [0:LATENCY-1];
  stage_t out_d  [0:LATENCY-1];
  stage_t data_q [1:LATENCY];
  logic   vld_q  [1:LATENCY];

  always_comb begin
    in_d[0]   = {18'd0, 16'd0, bus.x};
    vld_in[0] = bus.x_vld;
    for (int s = 1; s < LATENCY; s++) begin
      in_d[s]   = data_q[s];
      vld_in[s] = vld_q[s];
    end
    for (int s = 0; s < LATENCY; s++) begin
      out_d[s] = run_stage(in_d[s]);
    end
  end

  // Valid bits load every cycle and clear on reset.
  // Data loads only behind a valid, and reset leaves it untouched.
  always_ff @(posedge clk) begin
    for (int s = 0; s < LATENCY; s++) begin
      if (rst) begin
        vld_q[s+1] <= 1'b0;
      end else begin
        vld_q[s+1] <= vld_in[s];
      end
      if (vld_in[s]) begin
        data_q[s+1] <= out_d[s];
      end
    end
  end

  assign bus.y_vld = vld_q[LATENCY];
  assign bus.y     = data_q[LATENCY].root;

endmodule

// File: tb/tb_isqrt_pipelined.sv
// Directed bench for isqrt_pipelined.
// Three instances run side by side, with ITER_PER_STAGE = 1, 4 and 16
// (latency 16, 4 and 1). They share the same stimulus.
// Each instance has its own expected queue. An entry holds the edge number at
// which the result must be visible, packed together with the expected root.
module tb_isqrt_pipelined;
  localparam int LAT0 = 16;
  localparam int LAT1 = 4;
  localparam int LAT2 = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        x_vld = 1'b0;
  logic [31:0] x = 32'd0;
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;

  logic [47:0] exp_q0[$];
  logic [47:0] exp_q1[$];
  logic [47:0] exp_q2[$];

  isqrt_pipelined_if if0();
  isqrt_pipelined_if if1();
  isqrt_pipelined_if if2();

  assign if0.x_vld = x_vld;
  assign if0.x     = x;
  assign if1.x_vld = x_vld;
  assign if1.x     = x;
  assign if2.x_vld = x_vld;
  assign if2.x     = x;

  isqrt_pipelined #(.ITER_PER_STAGE(1))  dut0 (.clk(clk), .rst(rst), .bus(if0));
  isqrt_pipelined #(.ITER_PER_STAGE(4))  dut1 (.clk(clk), .rst(rst), .bus(if1));
  isqrt_pipelined #(.ITER_PER_STAGE(16)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  // Clock / edge counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparison helper
  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: binary search on 64-bit squares
  function automatic logic [15:0] isqrt_ref(input logic [31:0] v);
    longint lo;
    longint hi;
    longint mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= longint'(v)) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  // Scoreboard: outputs are sampled 1 time unit after each rising edge.
  task automatic check_out(input int id, input logic vld, input logic [15:0] yv);
    logic [47:0] e;
    bit          have;
    have = 1'b0;
    e = '0;
    case (id)
      0: if (exp_q0.size() > 0 && exp_q0[0][47:16] == 32'(cyc)) begin e = exp_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0 && exp_q1[0][47:16] == 32'(cyc)) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0 && exp_q2[0][47:16] == 32'(cyc)) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (vld === 1'b1 || have) begin
      check($sformatf("y_vld%0d", id), {47'd0, vld}, {47'd0, have});
      if (have && vld === 1'b1) check($sformatf("y%0d", id), {32'd0, yv}, {32'd0, e[15:0]});
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check_out(0, if0.y_vld, if0.y);
      check_out(1, if1.y_vld, if1.y);
      check_out(2, if2.y_vld, if2.y);
    end
  end

  // Driver tasks: called at a falling edge, and they return at the next falling edge.
  task automatic issue(input logic [31:0] xv, input logic [15:0] yv);
    x_vld = 1'b1;
    x = xv;
    exp_q0.push_back({32'(cyc + LAT0), yv});
    exp_q1.push_back({32'(cyc + LAT1), yv});
    exp_q2.push_back({32'(cyc + LAT2), yv});
    @(negedge clk);
    x_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    x_vld = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // One-cycle reset with a coincident x_vld that must be ignored.
  task automatic pulse_reset();
    rst = 1'b1;
    x_vld = 1'b1;
    x = 32'd49;
    @(posedge clk);
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
    @(negedge clk);
    rst = 1'b0;
    x_vld = 1'b0;
  endtask

  initial begin
    logic [31:0] xr;
    logic [31:0] r;
    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_vld0", {47'd0, if0.y_vld}, 48'd0);
    check("rst_vld1", {47'd0, if1.y_vld}, 48'd0);
    check("rst_vld2", {47'd0, if2.y_vld}, 48'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Single zero
    issue(32'd0, 16'd0);
    idle(20);

    // Back-to-back 16, 17, 24, then 25
    issue(32'd16, 16'd4);
    issue(32'd17, 16'd4);
    issue(32'd24, 16'd4);
    idle(2);
    issue(32'd25, 16'd5);
    idle(3);

    // Top-end boundaries
    issue(32'hFFFF_FFFF, 16'hFFFF);
    issue(32'hFFFE_0001, 16'hFFFF);
    issue(32'hFFFE_0000, 16'hFFFE);
    issue(32'hFFFF_FFFE, 16'hFFFF);

    // Gap pattern 1,0,1,1,0
    issue(32'd1, 16'd1);
    idle(1);
    issue(32'd2, 16'd1);
    issue(32'd3, 16'd1);
    idle(1);

    // Squares and squares minus one
    issue(32'd4, 16'd2);
    issue(32'd99, 16'd9);
    issue(32'd100, 16'd10);
    issue(32'd65535, 16'd255);
    issue(32'd65536, 16'd256);
    issue(32'h3FFF_FFFF, 16'd32767);
    issue(32'h4000_0000, 16'd32768);
    issue(32'd999999, 16'd999);
    issue(32'd1000000, 16'd1000);
    idle(20);

    // Five requests, then reset while the last three are still in the longest pipe
    issue(32'd36, 16'd6);
    issue(32'd49, 16'd7);
    issue(32'd64, 16'd8);
    issue(32'd81, 16'd9);
    issue(32'd121, 16'd11);
    idle(12);
    pulse_reset();
    issue(32'd144, 16'd12);
    idle(20);

    // Random arguments, biased toward squares and squares +/- 1, with random gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 3) == 0) begin
          xr = $urandom;
        end else begin
          r = 32'($urandom_range(0, 65535));
          xr = r * r + 32'($urandom_range(0, 2)) - 32'd1;
        end
        issue(xr, isqrt_ref(xr));
      end else begin
        idle(1);
      end
    end
    idle(20);

    // Every expected result must have appeared
    check("drain0", 48'(exp_q0.size()), 48'd0);
    check("drain1", 48'(exp_q1.size()), 48'd0);
    check("drain2", 48'(exp_q2.size()), 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
